// File: rtl/pad_row_rmw.sv
// Read-modify-write row assembler: merges narrow elements into padded RAM rows.
// A row is read once, filled lane by lane, then written back on flush or fill.
module pad_row_rmw #(
  parameter  int ELEM_W = 48,
  parameter  int LANE_W = 64,
  parameter  int LANES  = 4,
  parameter  int ADDR_W = 11,
  localparam int LIDX_W = $clog2(LANES),
  localparam int ROW_W  = LANES * LANE_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     ElemValid,
  output logic                     ElemReady,
  input  logic [ELEM_W-1:0]        Element,
  input  logic [ADDR_W+LIDX_W-1:0] PosElement,
  input  logic                     Flush,
  output logic                     RamRdEn,
  output logic [ADDR_W-1:0]        RamAddr,
  input  logic [ROW_W-1:0]         Y_ramRow,
  output logic                     RamWrEn,
  output logic [ROW_W-1:0]         PaddedRow,
  output logic                     RowReady
);

  typedef enum logic [2:0] {
    IDLE, RD, RDW, OPEN, WR
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    buf_q, buf_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   prow_q, prow_d;
  logic [LIDX_W-1:0]   plane_q, plane_d;
  logic [ELEM_W-1:0]   pdata_q, pdata_d;

  logic [ADDR_W-1:0]   elem_row;
  logic [LIDX_W-1:0]   elem_lane;
  logic                ready;
  logic                accept;
  logic                rd_en;
  logic                wr_en;
  logic [ADDR_W-1:0]   addr;

  assign elem_row  = PosElement[LIDX_W +: ADDR_W];
  assign elem_lane = PosElement[LIDX_W-1:0];

  // Only the element field is touched; lane padding bits pass through.
  function automatic logic [ROW_W-1:0] merge(
    input logic [ROW_W-1:0]  r,
    input logic [LIDX_W-1:0] lane,
    input logic [ELEM_W-1:0] d
  );
    logic [ROW_W-1:0] o;
    o = r;
    for (int k = 0; k < LANES; k++) begin
      if (lane == LIDX_W'(k)) begin
        o[(LANES-1-k)*LANE_W +: ELEM_W] = d;
      end
    end
    return o;
  endfunction

  function automatic logic [LANES-1:0] onehot(
    input logic [LIDX_W-1:0] lane
  );
    return LANES'(1) << lane;
  endfunction

  assign ready  = (state_q == IDLE) || (state_q == OPEN);
  assign accept = ElemValid & ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    mask_d  = mask_q;
    row_d   = row_q;
    pend_d  = pend_q;
    prow_d  = prow_q;
    plane_d = plane_q;
    pdata_d = pdata_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = 1'b1;
          prow_d  = elem_row;
          plane_d = elem_lane;
          pdata_d = Element;
          state_d = RD;
        end
      end
      RD: begin
        rd_en   = 1'b1;
        addr    = prow_q;
        state_d = RDW;
      end
      RDW: begin
        buf_d   = merge(Y_ramRow, plane_q, pdata_q);
        mask_d  = onehot(plane_q);
        row_d   = prow_q;
        pend_d  = 1'b0;
        prow_d  = '0;
        plane_d = '0;
        pdata_d = '0;
        state_d = OPEN;
      end
      OPEN: begin
        if (accept && (elem_row == row_q)) begin
          buf_d  = merge(buf_q, elem_lane, Element);
          mask_d = mask_q | onehot(elem_lane);
        end else if (accept) begin
          pend_d  = 1'b1;
          prow_d  = elem_row;
          plane_d = elem_lane;
          pdata_d = Element;
          state_d = WR;
        end
        if (Flush || (&mask_d)) begin
          state_d = WR;
        end
      end
      WR: begin
        wr_en   = 1'b1;
        addr    = row_q;
        mask_d  = '0;
        state_d = pend_q ? RD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      pend_q  <= 1'b0;
      prow_q  <= '0;
      plane_q <= '0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      pend_q  <= pend_d;
      prow_q  <= prow_d;
      plane_q <= plane_d;
      pdata_q <= pdata_d;
    end
  end

  // IDLE is the reset state, so readiness must be masked while in reset.
  assign ElemReady = ready & Rst_n;
  assign RamRdEn   = rd_en;
  assign RamWrEn   = wr_en;
  assign RowReady  = wr_en;
  assign RamAddr   = addr;
  assign PaddedRow = wr_en ? buf_q : '0;

endmodule

// File: doc/pad_row_rmw.md
PAD_ROW_RMW -- requirements
Module: pad_row_rmw

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ELEM_W, 48, element width in bits.
- LANE_W, 64, lane width in bits; SHALL satisfy LANE_W >= ELEM_W.
- LANES, 4, lanes per row; SHALL be a power of two >= 2.
- ADDR_W, 11, row address width.
- Derived: LIDX_W = log2(LANES); ROW_W = LANES*LANE_W.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, single clock; all state changes on its rising edge.
- Rst_n, in, 1, reset; asynchronous, active-low.
- ElemValid, in, 1, an element is offered this cycle.
- ElemReady, out, 1, the block accepts an element this cycle.
- Element, in, ELEM_W, element data.
- PosElement, in, ADDR_W+LIDX_W, row address in the upper ADDR_W bits, lane index in the lower LIDX_W bits.
- Flush, in, 1, write the open row back to RAM.
- RamRdEn, out, 1, RAM read strobe.
- RamAddr, out, ADDR_W, RAM row address for both read and write.
- Y_ramRow, in, ROW_W, RAM read data, valid exactly 1 cycle after RamRdEn.
- RamWrEn, out, 1, RAM write strobe.
- PaddedRow, out, ROW_W, RAM write data.
- RowReady, out, 1, 1-cycle pulse coincident with RamWrEn.

Function
REQ-003 An element SHALL transfer only on a cycle where ElemValid=1 and ElemReady=1.
REQ-004 Lane k SHALL occupy row bits [(LANES-1-k)*LANE_W + ELEM_W-1 : (LANES-1-k)*LANE_W]; lane 0 is most significant.
REQ-005 A merge SHALL replace only the ELEM_W field of the addressed lane; every other bit of the row, including lane bits above ELEM_W, SHALL be preserved.
REQ-006 The state machine SHALL have five states: IDLE, RD, RDW, OPEN, WR.
REQ-007 IDLE: ElemReady=1; an accepted element is latched as pending (row, lane, data); next state RD.
REQ-008 IDLE: Flush with no element SHALL be ignored.
REQ-009 RD: RamRdEn=1, RamAddr = pending row, ElemReady=0; next state RDW.
REQ-010 RDW: ElemReady=0; Buffer <= Y_ramRow with the pending element merged; lane mask <= one-hot(pending lane); pending cleared; next state OPEN.
REQ-011 OPEN: ElemReady=1. A same-row element SHALL merge into Buffer in the same cycle and set its mask bit. Writing the same lane twice: last value wins.
REQ-012 OPEN, different-row element accepted: latch it as pending; next state WR.
REQ-013 OPEN, Flush=1: next state WR. If a same-row element is accepted in the same cycle, it SHALL be merged before the write.
REQ-014 OPEN: when the lane mask becomes all ones, next state SHALL be WR (auto-flush).
REQ-015 OPEN: with no element, no Flush and the mask not full, the row SHALL stay open indefinitely.
REQ-016 WR: RamWrEn=1, RowReady=1, RamAddr = open row, PaddedRow = Buffer, ElemReady=0; mask cleared; next state RD if pending is set, else IDLE.
REQ-017 RamRdEn and RamWrEn SHALL never be asserted in the same cycle.
REQ-018 PaddedRow SHALL be 0 in every state other than WR.
REQ-019 Latency: from element acceptance in IDLE to first ElemReady in OPEN is 3 cycles; from the row-closing event to RamWrEn is 1 cycle.

Reset
REQ-020 While Rst_n=0 the block SHALL be in state IDLE, with Buffer, lane mask and pending all 0, and all outputs 0.
REQ-021 Assertion of Rst_n SHALL take effect asynchronously: an in-progress RD or WR strobe drops immediately and the open row is discarded without being written.
REQ-022 The first cycle after Rst_n deasserts SHALL be IDLE with ElemReady=1.

Verification
REQ-023 Row 5 in RAM all ones; element 0x123456789ABC to row 5, lane 3; then Flush -> a single write to address 5 with PaddedRow = all ones except bits[47:0] = 0x123456789ABC.
REQ-024 Four back-to-back elements to row 2, lanes 0-3, RAM row all zero -> exactly one read and one write; each lane holds its element in bits[47:0] of the lane with bits 63:48 = 0; write occurs 1 cycle after the lane 3 element.
REQ-025 Row 1 open; element for row 9 -> write of row 1, then read of row 9 on the next cycle; the row-9 element is present in the next write.
REQ-026 Lane 1 written with 0xAAAA_AAAA_AAAA, then 0x5555_5555_5555, then Flush -> lane 1 field = 0x555555555555.
REQ-027 Rst_n pulled low during WR -> RamWrEn=0 within the same cycle; after release, ElemReady=1 and no write of the old row occurs.
REQ-028 Flush in IDLE; a same-row element together with Flush in OPEN -> the first produces no RAM activity; the second merges the element and then writes.
